ins_enc: RTL and testbench

Instruction encoder and program loader for the 4-bit CPU. It packs per-field instruction descriptions into the 11-bit instruction word the core's instruction decoder consumes. It also writes the packed words into instruction memory at consecutive addresses, starting at 0. It sits between the test/boot host and the instruction memory write port, and is the producer side of the 11-bit instruction format.

---
 rtl/ins_enc.sv | 159 +++++++++++++++
 tb/tb_ins_enc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_enc.sv
// ----------------------------------------------------------------------------
// ins_enc -- instruction encoder and program loader for the 4-bit CPU.
//
// Packs per-field instruction descriptions into the 11-bit instruction word
// the core's decoder consumes. Each packed word is written to instruction
// memory at consecutive addresses, starting at 0, one word per accepted
// bundle.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse that opens a load session (IDLE only)
//   in_valid/ready  bundle handshake; in_ready is high only while loading
//   in_last         bundle is the final instruction of the session
//   op_kind         0=ALU, 1=LDI, 2=JMP, 3=NOP
//   alu_op, sel_w, sel_a, sel_b, imm, jmp   instruction fields
//   mem_we/addr/data  registered instruction memory write port
//   done            one-cycle pulse when a session ends
//   count           words written in the current or most recent session
//   overflow        sticky: memory filled before in_last was seen
// ----------------------------------------------------------------------------
module ins_enc #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        op_kind,
  input  logic              alu_op,
  input  logic [1:0]        sel_w,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  input  logic [3:0]        imm,
  input  logic [3:0]        jmp,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [10:0]       mem_data,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] OP_ALU = 2'd0;
  localparam logic [1:0] OP_LDI = 2'd1;
  localparam logic [1:0] OP_JMP = 2'd2;
  localparam logic [1:0] OP_NOP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Pack one instruction; fields not used by the opcode are forced to 0.
  function automatic logic [10:0] encode_word(
    input logic [1:0] kind,
    input logic       f_alu_op,
    input logic [1:0] f_sel_w,
    input logic [1:0] f_sel_a,
    input logic [1:0] f_sel_b,
    input logic [3:0] f_imm,
    input logic [3:0] f_jmp
  );
    logic [10:0] w;
    case (kind)
      OP_ALU:  w = {3'b000, 1'b0, f_alu_op, f_sel_w, f_sel_a, f_sel_b};
      OP_LDI:  w = {3'b010, 2'b00, f_sel_w, f_imm};
      OP_JMP:  w = {3'b100, f_jmp, 4'b0000};
      OP_NOP:  w = {3'b011, 8'h00};
      default: w = 11'h000;
    endcase
    return w;
  endfunction

  state_e              state_q;
  logic [ADDR_W-1:0]   wp_q;
  logic [ADDR_W:0]     count_q;
  logic                overflow_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [10:0]         mem_data_q;

  logic [10:0]         enc_word_d;
  logic [ADDR_W-1:0]   wp_d;
  logic [ADDR_W:0]     count_d;
  logic                at_last_addr_s;

  // Next-value helpers for the datapath registers.
  always_comb begin
    enc_word_d     = encode_word(op_kind, alu_op, sel_w, sel_a, sel_b, imm, jmp);
    wp_d           = wp_q + ADDR_W'(1);
    count_d        = count_q + (ADDR_W + 1)'(1);
    at_last_addr_s = (wp_q == LAST_ADDR);
  end

  // Session FSM with the registered memory write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 11'h000;
    end else begin
      // The strobe is a single-cycle pulse following each transfer.
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            wp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= wp_q;
            mem_data_q <= enc_word_d;
            wp_q       <= wp_d;
            count_q    <= count_d;
            // The last address ends the session; without in_last the
            // program did not fit, which is flagged as overflow.
            if (in_last || at_last_addr_s) begin
              state_q <= S_DONE;
            end
            if (at_last_addr_s && !in_last) begin
              overflow_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // in_ready and done decode the registered state only.
  assign in_ready = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ins_enc.sv
module tb_ins_enc;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [1:0]        op_kind = 2'd0;
  logic              alu_op = 1'b0;
  logic [1:0]        sel_w = 2'd0;
  logic [1:0]        sel_a = 2'd0;
  logic [1:0]        sel_b = 2'd0;
  logic [3:0]        imm = 4'd0;
  logic [3:0]        jmp = 4'd0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [10:0]       mem_data;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              overflow;

  ins_enc #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .op_kind(op_kind),
    .alu_op(alu_op), .sel_w(sel_w), .sel_a(sel_a), .sel_b(sel_b),
    .imm(imm), .jmp(jmp), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .done(done), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: what the loader has promised so far.
  bit m_loading = 1'b0;   // session open, accepting bundles
  bit m_ending  = 1'b0;   // session just closed (done cycle)
  int m_count   = 0;
  bit m_ovf     = 1'b0;
  bit m_we      = 1'b0;
  int m_addr    = 0;
  int m_data    = 0;

  // Observed writes, for literal checks of directed sessions.
  int log_addr[$];
  int log_data[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction word from the field rules, in plain arithmetic.
  function automatic int ref_enc(input int k, input int aop, input int w,
                                 input int a, input int b, input int im, input int j);
    case (k)
      0: return aop * 64 + w * 16 + a * 4 + b;
      1: return 2 * 256 + w * 16 + im;
      2: return 4 * 256 + j * 16;
      default: return 3 * 256;
    endcase
  endfunction

  // Model: advance on every rising edge using the inputs seen there.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_loading = 0; m_ending = 0; m_count = 0; m_ovf = 0;
        m_we = 0; m_addr = 0; m_data = 0;
      end else begin
        m_we = 0;
        if (m_ending) begin
          m_ending = 0;
        end else if (m_loading) begin
          if (in_valid) begin
            m_we   = 1;
            m_addr = m_count;
            m_data = ref_enc(op_kind, alu_op, sel_w, sel_a, sel_b, imm, jmp);
            m_count++;
            if (in_last || m_count == DEPTH) begin
              m_loading = 0;
              m_ending  = 1;
              if (!in_last) m_ovf = 1;
            end
          end
        end else if (start) begin
          m_loading = 1; m_count = 0; m_ovf = 0;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1) begin
        log_addr.push_back(int'(mem_addr));
        log_data.push_back(int'(mem_data));
      end
      if (chk_en) begin
        chk("in_ready", 16'(in_ready), 16'(m_loading));
        chk("done",     16'(done),     16'(m_ending));
        chk("mem_we",   16'(mem_we),   16'(m_we));
        chk("mem_addr", 16'(mem_addr), 16'(m_addr));
        chk("mem_data", 16'(mem_data), 16'(m_data));
        chk("count",    16'(count),    16'(m_count));
        chk("overflow", 16'(overflow), 16'(m_ovf));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 0; in_valid = 0; in_last = 0; op_kind = 0; alu_op = 0;
    sel_w = 0; sel_a = 0; sel_b = 0; imm = 0; jmp = 0;
  endtask

  // Present one bundle for one cycle.
  task automatic put(input int k, input int aop, input int w, input int a,
                     input int b, input int im, input int j, input bit last, input bit v);
    in_valid = v; in_last = last; op_kind = 2'(k); alu_op = aop[0];
    sel_w = 2'(w); sel_a = 2'(a); sel_b = 2'(b); imm = 4'(im); jmp = 4'(j);
    tick(1);
  endtask

  task automatic open_session();
    start = 1; tick(1); start = 0;
  endtask

  int base;

  initial begin
    // Reset then idle.
    rst = 1; tick(2); rst = 0; chk_en = 1;
    tick(10);
    @(negedge clk); #1;
    chk("idle_ready", 16'(in_ready), 16'd0);
    chk("idle_count", 16'(count), 16'd0);
    chk("idle_we", 16'(mem_we), 16'd0);
    tick(1);

    // Four-op session, back to back.
    base = log_addr.size();
    open_session();
    put(0, 1, 2, 1, 3, 0, 0, 0, 1);
    put(1, 0, 1, 0, 0, 10, 0, 0, 1);
    put(2, 0, 0, 0, 0, 0, 5, 0, 1);
    put(3, 0, 0, 0, 0, 0, 0, 1, 1);
    clear_in();
    @(negedge clk); #1;
    chk("four_done_with_we", 16'({done, mem_we, in_ready}), 16'b110);
    tick(3);
    chk("four_nwrites", 16'(log_addr.size() - base), 16'd4);
    if (log_addr.size() - base == 4) begin
      chk("four_a0", 16'(log_addr[base]),   16'd0); chk("four_d0", 16'(log_data[base]),   16'h067);
      chk("four_a1", 16'(log_addr[base+1]), 16'd1); chk("four_d1", 16'(log_data[base+1]), 16'h21A);
      chk("four_a2", 16'(log_addr[base+2]), 16'd2); chk("four_d2", 16'(log_data[base+2]), 16'h450);
      chk("four_a3", 16'(log_addr[base+3]), 16'd3); chk("four_d3", 16'(log_data[base+3]), 16'h300);
    end
    chk("four_count", 16'(count), 16'd4);
    chk("four_ovf", 16'(overflow), 16'd0);

    // Valid gaps.
    base = log_addr.size();
    open_session();
    put(3, 0, 0, 0, 0, 0, 0, 0, 1);
    put(3, 0, 0, 0, 0, 0, 0, 0, 0);
    put(3, 0, 0, 0, 0, 0, 0, 0, 0);
    put(1, 0, 3, 0, 0, 7, 0, 0, 1);
    put(2, 0, 0, 0, 0, 0, 9, 1, 1);
    clear_in(); tick(3);
    chk("gap_nwrites", 16'(log_addr.size() - base), 16'd3);
    if (log_addr.size() - base == 3)
      chk("gap_a2", 16'(log_addr[base+2]), 16'd2);
    chk("gap_count", 16'(count), 16'd3);

    // Overflow: 16 NOPs without in_last, then a 17th valid.
    base = log_addr.size();
    open_session();
    for (int i = 0; i < DEPTH + 1; i++) put(3, 0, 0, 0, 0, 0, 0, 0, 1);
    clear_in(); tick(3);
    chk("ovf_nwrites", 16'(log_addr.size() - base), 16'd16);
    chk("ovf_last_addr", 16'(log_addr[log_addr.size()-1]), 16'd15);
    chk("ovf_count", 16'(count), 16'd16);
    chk("ovf_flag", 16'(overflow), 16'd1);

    // Reset on the edge of the third transfer.
    base = log_addr.size();
    open_session();
    put(3, 0, 0, 0, 0, 0, 0, 0, 1);
    put(3, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1;
    put(0, 1, 1, 1, 1, 0, 0, 0, 1);
    rst = 0; clear_in(); tick(2);
    chk("rst_nwrites", 16'(log_addr.size() - base), 16'd2);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_ready", 16'(in_ready), 16'd0);
    base = log_addr.size();
    open_session();
    put(1, 0, 2, 0, 0, 3, 0, 1, 1);
    clear_in(); tick(3);
    chk("restart_nwrites", 16'(log_addr.size() - base), 16'd1);
    if (log_addr.size() - base == 1) begin
      chk("restart_a0", 16'(log_addr[base]), 16'd0);
      chk("restart_d0", 16'(log_data[base]), 16'h223);
    end

    // Ignored controls: start in LOAD and DONE, in_valid in IDLE.
    base = log_addr.size();
    open_session();
    start = 1; put(3, 0, 0, 0, 0, 0, 0, 0, 1);
    start = 0; put(3, 0, 0, 0, 0, 0, 0, 1, 1);
    start = 1; put(3, 0, 0, 0, 0, 0, 0, 0, 1);   // DONE cycle
    start = 0;
    for (int i = 0; i < 3; i++) put(0, 1, 1, 1, 1, 0, 0, 0, 1);
    clear_in(); tick(2);
    chk("ign_nwrites", 16'(log_addr.size() - base), 16'd2);
    chk("ign_count", 16'(count), 16'd2);
    chk("ign_ready", 16'(in_ready), 16'd0);

    // Randomized traffic, model-checked on every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 9) == 0);
      op_kind  = 2'($urandom); alu_op = 1'($urandom);
      sel_w = 2'($urandom); sel_a = 2'($urandom); sel_b = 2'($urandom);
      imm = 4'($urandom); jmp = 4'($urandom);
      tick(1);
    end
    rst = 0; clear_in(); tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
